// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit bridging the control unit to a req/ack memory port
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic        reg_write,
    output logic [4:0]  rd_out,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LW  = 2'b00;
    localparam logic [1:0] OP_SW  = 2'b01;
    localparam logic [1:0] OP_SB  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Last counter value seen in ACCESS before giving up on the ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [7:0]  cnt;
    logic        tmo_q;

    logic accept;
    logic start_misaligned;
    logic expire;

    assign accept           = (state == S_IDLE) && start && (op != OP_RSV);
    assign start_misaligned = (op != OP_SB) && (alu_out[1:0] != 2'b00);
    assign expire           = (state == S_ACCESS) && !mem_ack && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack on the expiry edge takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = start_misaligned ? S_ERROR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ERROR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latches, access counter, error cause and load result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= OP_LW;
            addr_q    <= '0;
            data_q    <= '0;
            rd_out    <= '0;
            cnt       <= '0;
            tmo_q     <= 1'b0;
            load_data <= '0;
        end else begin
            if (accept) begin
                op_q   <= op;
                addr_q <= alu_out;
                data_q <= store_data;
                rd_out <= rd_in;
                cnt    <= '0;
                tmo_q  <= 1'b0;
            end else if (state == S_ACCESS) begin
                cnt <= cnt + 8'd1;
            end
            if (expire) begin
                tmo_q <= 1'b1;
            end
            if ((state == S_ACCESS) && mem_ack && (op_q == OP_LW)) begin
                load_data <= mem_rdata;
            end
        end
    end

    // Status and memory-port outputs decoded from state and the latched operands.
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE) || (state == S_ERROR);
        reg_write  = (state == S_DONE) && (op_q == OP_LW);
        misaligned = (state == S_ERROR) && !tmo_q;
        timeout    = (state == S_ERROR) && tmo_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        if (state == S_ACCESS) begin
            mem_req  = 1'b1;
            mem_we   = (op_q != OP_LW);
            mem_addr = {addr_q[31:2], 2'b00};
            case (op_q)
                OP_SW: begin
                    mem_be    = 4'b1111;
                    mem_wdata = data_q;
                end
                OP_SB: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{data_q[7:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles in ACCESS awaiting mem_ack before abort (1..255).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request from control unit; sampled only in IDLE.
REQ-005 op  input  2  00 lw, 01 sw, 10 sb, 11 reserved.
REQ-006 alu_out  input  32  effective address from ALU sum (alu_sel 0000).
REQ-007 store_data  input  32  rs2 value for sw/sb.
REQ-008 rd_in  input  5  destination register for lw.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 reg_write  output  1  one-cycle pulse with done, successful lw only.
REQ-012 rd_out  output  5  latched rd_in, valid with reg_write.
REQ-013 load_data  output  32  captured mem_rdata, held until next lw completes.
REQ-014 misaligned  output  1  high with done when lw/sw address[1:0] != 00.
REQ-015 timeout  output  1  high with done when TIMEOUT expired.
REQ-016 mem_req  output  1  memory request, high throughout ACCESS.
REQ-017 mem_we  output  1  1 for sw/sb, 0 for lw.
REQ-018 mem_addr  output  32  {addr[31:2],2'b00}.
REQ-019 mem_wdata  output  32  write data.
REQ-020 mem_be  output  4  byte enables.
REQ-021 mem_ack  input  1  memory accepted/completed access.
REQ-022 mem_rdata  input  32  read data, valid when mem_ack high.

Function
REQ-023 FSM states IDLE, ACCESS, DONE, ERROR; encoded as registered state.
REQ-024 IDLE: start=1 with op in {00,01,10} latches op, alu_out, store_data, rd_in; next ACCESS, or ERROR if lw/sw misaligned.
REQ-025 start with op=11 shall be ignored; state stays IDLE, no outputs change.
REQ-026 start while busy shall be ignored; latched operands unchanged.
REQ-027 sb any alignment: mem_be = 4'b0001 << addr[1:0], mem_wdata = {4{store_data[7:0]}}.
REQ-028 sw/lw: mem_be = 1111; sw mem_wdata = store_data; lw mem_wdata = 0.
REQ-029 mem_req, mem_we, mem_addr, mem_be, mem_wdata stable for entire ACCESS; mem_req = 0 and mem_* = 0 outside ACCESS.
REQ-030 ACCESS: mem_ack sampled high -> capture mem_rdata into load_data if lw; next DONE.
REQ-031 ACCESS cycle counter 8 bits, cleared on entry; count reaching TIMEOUT without ack -> ERROR with timeout set; ack on same edge as expiry wins (normal DONE).
REQ-032 DONE: done=1, reg_write=1 iff lw, flags 0, one cycle, then IDLE.
REQ-033 ERROR: done=1, reg_write=0, misaligned or timeout set (exactly one), one cycle, then IDLE; no memory access for misaligned.
REQ-034 Latency: start at edge N, mem_req high cycle N+1; ack at edge K gives done high cycle K+1; minimum start-to-done 2 cycles.
REQ-035 New start accepted in IDLE the cycle after done; back-to-back throughput one access per 3 cycles minimum.
REQ-036 mem_ack outside ACCESS shall be ignored.

Reset
REQ-037 reset_n low asynchronously forces IDLE; busy, done, reg_write, misaligned, timeout, mem_req, mem_we = 0; mem_addr, mem_wdata, mem_be, load_data, rd_out, counter = 0.
REQ-038 Reset during ACCESS drops mem_req immediately; no done pulse follows release.
REQ-039 First start accepted on first rising edge after reset_n high.

Verification
REQ-040 lw: alu_out=0x00000010, rd_in=5, mem_ack 3 cycles after req with mem_rdata=0xDEADBEEF -> mem_addr=0x10, mem_be=1111, mem_we=0, then done=reg_write=1, rd_out=5, load_data=0xDEADBEEF.
REQ-041 sb: alu_out=0x00000013, store_data=0x000000A5, immediate ack -> mem_addr=0x10, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1, done 2 cycles after start, reg_write=0.
REQ-042 sw misaligned: alu_out=0x00000006 -> mem_req never asserted, next cycle done=1, misaligned=1.
REQ-043 Timeout: TIMEOUT=4, lw with mem_ack held 0 -> mem_req high 4 cycles, then done=1, timeout=1, load_data unchanged.
REQ-044 start pulsed during ACCESS with different op/address, and op=11 in IDLE -> both ignored; first transaction completes with original values.
REQ-045 reset_n low mid-ACCESS -> mem_req, busy 0 immediately; after release no done; next lw completes normally.
